// File: rtl/qspi_flash_pkg.sv
// rtl/qspi_flash_pkg.sv - opcodes, FSM state type and JEDEC ID byte select for the QSPI flash responder
package qspi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE} state_t;

  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      default: return id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/qspi_flash_resp_if.sv
// rtl/qspi_flash_resp_if.sv - byte-wide memory read port used by the QSPI flash responder
interface qspi_flash_resp_if #(
  parameter int AW = 24
);
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;

  modport master (output mem_rd_en, output mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/qspi_pin_sync.sv
// rtl/qspi_pin_sync.sv - multi-flop synchronizer plus one-flop edge detect for a small pin bus
module qspi_pin_sync #(
  parameter int W      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] stg;
  logic [W-1:0]             prev;

  // Reset to all-zero so a CS held low across reset release produces no fall edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg  <= '0;
      prev <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      prev <= stg[STAGES-1];
    end
  end

  assign q    = stg[STAGES-1];
  assign rise = stg[STAGES-1] & ~prev;
  assign fall = ~stg[STAGES-1] & prev;

endmodule

// File: rtl/qspi_flash_resp.sv
// rtl/qspi_flash_resp.sv - single-lane SPI-NOR responder: decodes READ/FAST_READ/RDID, serves bytes
// from a byte-wide memory read port, oversampling the SPI pins on sys_clk.
module qspi_flash_resp
  import qspi_flash_pkg::*;
#(
  parameter int          AW           = 24,
  parameter logic [23:0] JEDEC_ID     = 24'hC22018,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_cs_n_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  qspi_flash_resp_if.master mem,
  output logic              busy,
  output logic              cmd_err
);

  logic [2:0] pin_lvl, pin_rise, pin_fall;

  qspi_pin_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    ({spi_cs_n_i, spi_sck_i, spi_mosi_i}),
    .q    (pin_lvl),
    .rise (pin_rise),
    .fall (pin_fall)
  );

  logic cs_rise, cs_fall, sck_rise, sck_fall, mosi;
  assign cs_rise  = pin_rise[2];
  assign cs_fall  = pin_fall[2];
  assign sck_rise = pin_rise[1];
  assign sck_fall = pin_fall[1];
  assign mosi     = pin_lvl[0];

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_hold;
  logic [AW-1:0] addr;
  logic [1:0]    id_idx;
  logic          fast;
  logic          rd_en;
  logic          rd_load;
  logic [7:0]    rx_next;
  logic [7:0]    cur_byte;

  assign rx_next  = {rx_shift[6:0], mosi};
  assign cur_byte = (state == ID) ? id_byte(JEDEC_ID, id_idx) : tx_hold;

  assign mem.mem_rd_en   = rd_en;
  assign mem.mem_rd_addr = addr;

  logic unused_pins;
  assign unused_pins = ^{pin_lvl[2:1], pin_rise[0], pin_fall[0], rx_shift[7]};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= '0;
      addr        <= '0;
      id_idx      <= '0;
      fast        <= 1'b0;
      rd_en       <= 1'b0;
      rd_load     <= 1'b0;
      spi_miso_o  <= 1'b1;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
      rd_load <= rd_en;
      // Fetched byte is staged in tx_hold so the byte still shifting out is not clobbered.
      if (rd_load) tx_hold <= mem.mem_rd_data;

      if (cs_rise) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        spi_miso_oe <= 1'b0;
        spi_miso_o  <= 1'b1;
        busy        <= 1'b0;
        rd_load     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                case (rx_next)
                  OP_READ:  begin state <= ADDR; fast <= 1'b0; end
                  OP_FREAD: begin state <= ADDR; fast <= 1'b1; end
                  OP_RDID:  begin state <= ID;   id_idx <= '0; end
                  default:  begin state <= IGNORE; cmd_err <= 1'b1; end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              addr <= {addr[AW-2:0], mosi};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                rd_en   <= 1'b1;
                state   <= fast ? DUMMY : DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DUMMY: begin
            if (sck_rise) begin
              if (bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          DATA, ID: begin
            if (sck_rise) begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              // Fetch the next byte on the 7th rise; it lands in tx_hold well before the byte boundary.
              if (state == DATA && bit_cnt == 5'd6) begin
                addr  <= addr + AW'(1);
                rd_en <= 1'b1;
              end
            end
            if (sck_fall) begin
              spi_miso_oe <= 1'b1;
              if (bit_cnt == 5'd0) begin
                spi_miso_o <= cur_byte[7];
                tx_shift   <= {cur_byte[6:0], 1'b0};
                if (state == ID) id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end else begin
                spi_miso_o <= tx_shift[7];
                tx_shift   <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_resp.sv
// tb/tb_qspi_flash_resp.sv - scoreboard bench for qspi_flash_resp: directed SPI frames, queued
// expected bytes/addresses checked by independent monitors.
module tb_qspi_flash_resp;

  localparam int HALF = 5;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy, cmd_err;

  qspi_flash_resp_if #(.AW(24)) mem_if ();

  qspi_flash_resp #(.AW(24), .JEDEC_ID(24'hC22018), .DUMMY_CYCLES(8), .SYNC_STAGES(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .spi_cs_n_i (spi_cs_n),
    .spi_sck_i  (spi_sck),
    .spi_mosi_i (spi_mosi),
    .spi_miso_o (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem        (mem_if),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int err_count = 0;
  int mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0]  exp_data [$];
  logic [23:0] exp_addr [$];
  logic [7:0]  mem [logic [23:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  initial mem_if.mem_rd_data = 8'h00;
  always @(posedge sys_clk)
    if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem_byte(mem_if.mem_rd_addr);

  // Read-strobe and cmd_err monitor, sampled mid-cycle.
  initial forever begin
    @(negedge sys_clk);
    if (cmd_err) err_count++;
    if (mem_if.mem_rd_en) begin
      rd_count++;
      if (exp_addr.size() == 0) check("rd_addr_unexpected", mem_if.mem_rd_addr, 24'hxxxxxx);
      else check("rd_addr", mem_if.mem_rd_addr, exp_addr.pop_front());
    end
  end

  // MISO byte monitor: collects bits at each SCK rise while the output is enabled.
  initial forever begin
    @(posedge spi_sck);
    if (spi_miso_oe) begin
      mon_byte = {mon_byte[6:0], spi_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_data.size() == 0) check("miso_unexpected", mon_byte, 32'hxx);
        else check("miso_byte", mon_byte, exp_data.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge spi_cs_n);
    if (mon_bits != 0) check("miso_partial_bits", mon_bits, 0);
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog: no finish after 500000 ns");
    $fatal(1);
  end

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    repeat (HALF) @(negedge sys_clk);
    spi_sck = 1'b1;
    repeat (HALF) @(negedge sys_clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge sys_clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge sys_clk);
  endtask

  task automatic read_hdr(input logic [7:0] op, input logic [23:0] a);
    spi_byte(op);
    spi_byte(a[23:16]);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
  endtask

  initial begin
    mem[24'h000010] = 8'hA5; mem[24'h000011] = 8'h3C;
    mem[24'h000012] = 8'h00; mem[24'h000013] = 8'hFF;
    mem[24'h000014] = 8'h77; mem[24'h000100] = 8'h5A;
    mem[24'h000101] = 8'hC3; mem[24'hFFFFFF] = 8'h96;
    mem[24'h000000] = 8'hE1; mem[24'h000001] = 8'h0F;

    repeat (4) @(negedge sys_clk);
    check("rst_miso", spi_miso, 1'b1);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", mem_if.mem_rd_en, 1'b0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // 1: READ 0x000010, 4 bytes
    exp_data = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    exp_addr = '{24'h000010, 24'h000011, 24'h000012, 24'h000013, 24'h000014};
    cs_low();
    check("busy_frame", busy, 1'b1);
    read_hdr(8'h03, 24'h000010);
    repeat (4) spi_byte(8'h00);
    cs_high();
    check("busy_after_read", busy, 1'b0);
    check("oe_after_read", spi_miso_oe, 1'b0);

    // 2: FAST_READ 0x000100, 8 dummy, 2 bytes
    exp_data = '{8'h5A, 8'hC3};
    exp_addr = '{24'h000100, 24'h000101, 24'h000102};
    cs_low();
    read_hdr(8'h0B, 24'h000100);
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'b1);
      check("oe_dummy", spi_miso_oe, 1'b0);
    end
    repeat (2) spi_byte(8'h00);
    cs_high();

    // 3: RDID, 6 bytes
    exp_data = '{8'hC2, 8'h20, 8'h18, 8'hC2, 8'h20, 8'h18};
    cs_low();
    spi_byte(8'h9F);
    repeat (6) spi_byte(8'h00);
    cs_high();
    check("rdid_no_reads", rd_count, 8);

    // 4: unsupported opcode, then a normal READ
    cs_low();
    spi_byte(8'h05);
    repeat (16) spi_bit(1'b0);
    check("bad_op_err_once", err_count, 1);
    check("bad_op_busy", busy, 1'b1);
    check("bad_op_oe", spi_miso_oe, 1'b0);
    cs_high();
    check("bad_op_busy_release", busy, 1'b0);
    exp_data = '{8'h00};
    exp_addr = '{24'h000012, 24'h000013};
    cs_low();
    read_hdr(8'h03, 24'h000012);
    spi_byte(8'h00);
    cs_high();

    // 5: address wrap, then a frame aborted mid-address
    exp_data = '{8'h96, 8'hE1};
    exp_addr = '{24'hFFFFFF, 24'h000000, 24'h000001};
    cs_low();
    read_hdr(8'h03, 24'hFFFFFF);
    repeat (2) spi_byte(8'h00);
    cs_high();
    cs_low();
    spi_byte(8'h03);
    repeat (12) spi_bit(1'b1);
    cs_high();
    check("abort_no_reads", rd_count, 13);
    check("abort_busy", busy, 1'b0);

    // 6: reset pulse mid-DATA, then a clean frame
    exp_data = '{8'hA5};
    exp_addr = '{24'h000010, 24'h000011};
    cs_low();
    read_hdr(8'h03, 24'h000010);
    spi_byte(8'h00);
    repeat (3) spi_bit(1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    check("mid_rst_miso", spi_miso, 1'b1);
    check("mid_rst_oe", spi_miso_oe, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd_err", cmd_err, 1'b0);
    check("mid_rst_rd_en", mem_if.mem_rd_en, 1'b0);
    check("mid_rst_rd_addr", mem_if.mem_rd_addr, 24'h000000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_bits = 0;
    repeat (4) @(negedge sys_clk);
    check("mid_rst_stay_idle", busy, 1'b0);
    cs_high();
    exp_data = '{8'hFF};
    exp_addr = '{24'h000013, 24'h000014};
    cs_low();
    read_hdr(8'h03, 24'h000013);
    spi_byte(8'h00);
    cs_high();

    check("data_queue_drained", exp_data.size(), 0);
    check("addr_queue_drained", exp_addr.size(), 0);
    check("total_reads", rd_count, 17);
    check("total_cmd_err", err_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
